// File: rtl/fortaegis_capture.sv
// Armed, triggered circular capture buffer for the Fortaegis sensor path.
// Keeps pre-trigger history, records a post-trigger tail, then freezes it.
module fortaegis_capture #(
  parameter int CH = 4,
  parameter int W = 16,
  parameter int DEPTH = 256,
  parameter int PRE = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk350,
  input  logic            rst,
  input  logic            collect,
  input  logic [CH*W-1:0] din,
  input  logic            din_valid,
  input  logic            trig_ext,
  input  logic            thr_en,
  input  logic [W-1:0]    threshold,
  input  logic [AW-1:0]   post_cnt,
  input  logic [AW-1:0]   rd_addr,
  output logic [CH*W-1:0] rd_data,
  output logic            busy,
  output logic            done,
  output logic [CH:0]     trig_src,
  output logic [AW-1:0]   trig_idx,
  output logic [AW:0]     count
);

  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   PRE_F = (AW+1)'(PRE);
  localparam logic [AW-1:0] POST_MAX = AW'(DEPTH - 1 - PRE);

  typedef enum logic [2:0] {
    IDLE, ARMED, WAIT_TRIG, POST, DONE
  } state_t;

  state_t state, state_nxt;

  logic            collect_q;
  logic [AW-1:0]   wr_ptr, post_q, post_left;
  logic [AW-1:0]   trig_wr, start;
  logic [AW:0]     fill;
  logic [CH*W-1:0] mem [DEPTH];

  logic            rise, arm, abort, write, trig;
  logic            enter_done;
  logic [CH-1:0]   hit;
  logic [AW-1:0]   wr_inc, start_f, tw;
  logic [AW:0]     fill_inc;

  assign rise = collect & ~collect_q;
  assign busy = (state == ARMED) || (state == WAIT_TRIG) ||
                (state == POST);
  assign done = (state == DONE);
  assign arm = rise && ((state == IDLE) || (state == DONE));
  assign abort = busy && !collect;
  // An aborting sample still lands in memory; only the counters drop.
  assign write = busy && din_valid;

  always_comb begin
    hit = '0;
    for (int c = 0; c < CH; c++)
      hit[c] = din[c*W +: W] > threshold;
  end

  assign trig = (state == WAIT_TRIG) && din_valid &&
                (trig_ext || (thr_en && |hit));

  assign wr_inc = wr_ptr + AW'(1);
  assign fill_inc = (fill == FULL) ? fill : fill + 1'b1;

  // Layout of the frozen record, using post-write pointer values.
  assign start_f = (fill_inc == FULL) ? wr_inc : '0;
  assign tw = (state == WAIT_TRIG) ? wr_ptr : trig_wr;
  assign enter_done = (state_nxt == DONE) && (state != DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (rise) state_nxt = ARMED;
      ARMED: begin
        if (!collect) state_nxt = IDLE;
        else if (din_valid && fill_inc == PRE_F)
          state_nxt = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (!collect) state_nxt = IDLE;
        else if (trig)
          state_nxt = (post_q == '0) ? DONE : POST;
      end
      POST: begin
        if (!collect) state_nxt = IDLE;
        else if (din_valid && post_left == AW'(1))
          state_nxt = DONE;
      end
      DONE: if (rise) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk350 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      collect_q <= 1'b0;
      wr_ptr    <= '0;
      fill      <= '0;
      post_q    <= '0;
      post_left <= '0;
      trig_wr   <= '0;
      start     <= '0;
      trig_src  <= '0;
      trig_idx  <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      collect_q <= collect;
      if (arm) begin
        wr_ptr   <= '0;
        fill     <= '0;
        trig_src <= '0;
        trig_idx <= '0;
        count    <= '0;
        post_q   <= (post_cnt > POST_MAX) ? POST_MAX : post_cnt;
      end else if (abort) begin
        wr_ptr <= '0;
        fill   <= '0;
      end else if (write) begin
        wr_ptr <= wr_inc;
        fill   <= fill_inc;
      end
      if (trig && collect) begin
        trig_src  <= {trig_ext, hit & {CH{thr_en}}};
        trig_wr   <= wr_ptr;
        post_left <= post_q;
      end
      if (write && collect && state == POST)
        post_left <= post_left - AW'(1);
      if (enter_done) begin
        start    <= start_f;
        count    <= fill_inc;
        trig_idx <= tw - start_f;
      end
    end
  end

  always_ff @(posedge clk350) begin
    if (write) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk350 or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[start + rd_addr];
  end

endmodule

// File: tb/tb_fortaegis_capture.sv
// Directed bench for fortaegis_capture (CH=4, W=16, DEPTH=16, PRE=4).
// Expected values are hand-derived; written samples are kept in hist[].
module tb_fortaegis_capture;

  localparam int CH = 4;
  localparam int W = 16;
  localparam int DEPTH = 16;
  localparam int PRE = 4;
  localparam int AW = 4;

  logic            clk350 = 1'b0;
  logic            rst;
  logic            collect;
  logic [CH*W-1:0] din;
  logic            din_valid;
  logic            trig_ext;
  logic            thr_en;
  logic [W-1:0]    threshold;
  logic [AW-1:0]   post_cnt;
  logic [AW-1:0]   rd_addr;
  logic [CH*W-1:0] rd_data;
  logic            busy;
  logic            done;
  logic [CH:0]     trig_src;
  logic [AW-1:0]   trig_idx;
  logic [AW:0]     count;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] hist [128];

  fortaegis_capture #(
    .CH(CH), .W(W), .DEPTH(DEPTH), .PRE(PRE)
  ) dut (
    .clk350(clk350),
    .rst(rst),
    .collect(collect),
    .din(din),
    .din_valid(din_valid),
    .trig_ext(trig_ext),
    .thr_en(thr_en),
    .threshold(threshold),
    .post_cnt(post_cnt),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy(busy),
    .done(done),
    .trig_src(trig_src),
    .trig_idx(trig_idx),
    .count(count)
  );

  always #5 clk350 = ~clk350;

  task automatic tick();
    @(posedge clk350);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Channel c of sample n is {c, n}; optional bit-15 spike on one channel.
  function automatic logic [63:0] mk(input int n, input int spike);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) begin
      v[c*16 +: 16] = {8'(c), 8'(n)};
      if (c == spike) v[c*16 + 15] = 1'b1;
    end
    return v;
  endfunction

  task automatic feed(input int n, input bit v, input bit ext,
                      input int spike);
    din = mk(n, spike);
    din_valid = v;
    trig_ext = ext;
    tick();
    if (v) hist[n] = din;
    din_valid = 1'b0;
    trig_ext = 1'b0;
  endtask

  task automatic arm(input logic [3:0] pc, input bit te);
    post_cnt = pc;
    thr_en = te;
    collect = 1'b0;
    tick();
    collect = 1'b1;
    tick();
  endtask

  task automatic rd(input int a, input logic [63:0] exp,
                    input string tag);
    rd_addr = 4'(a);
    tick();
    chk(tag, rd_data, exp);
  endtask

  initial begin
    rst = 1'b1;
    collect = 1'b0;
    din = '0;
    din_valid = 1'b0;
    trig_ext = 1'b0;
    thr_en = 1'b0;
    threshold = 16'h7FFF;
    post_cnt = '0;
    rd_addr = '0;
    repeat (2) tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_src", 64'(trig_src), 64'(0));
    chk("rst_idx", 64'(trig_idx), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_rd", rd_data, 64'(0));
    rst = 1'b0;
    tick();

    // Threshold trigger on ch2 at n=9, three post samples.
    arm(4'd3, 1'b1);
    chk("basic_busy", 64'(busy), 64'(1));
    for (int n = 0; n < 12; n++) feed(n, 1'b1, 1'b0, (n == 9) ? 2 : -1);
    chk("basic_notdone", 64'(done), 64'(0));
    feed(12, 1'b1, 1'b0, -1);
    chk("basic_done", 64'(done), 64'(1));
    chk("basic_idle", 64'(busy), 64'(0));
    chk("basic_count", 64'(count), 64'(13));
    chk("basic_idx", 64'(trig_idx), 64'(9));
    chk("basic_src", 64'(trig_src), 64'(5'b00100));
    for (int a = 0; a < 13; a++) rd(a, hist[a], "basic_rd");

    // Wrap-around: trigger at n=30, ring wraps twice.
    arm(4'd3, 1'b1);
    for (int n = 0; n < 34; n++) feed(n, 1'b1, 1'b0, (n == 30) ? 2 : -1);
    chk("wrap_done", 64'(done), 64'(1));
    chk("wrap_count", 64'(count), 64'(16));
    chk("wrap_idx", 64'(trig_idx), 64'(12));
    rd(0, hist[18], "wrap_rd0");
    rd(12, hist[30], "wrap_rd12");
    rd(15, hist[33], "wrap_rd15");

    // Early trig_ext ignored while ARMED; zero post freezes on trigger.
    arm(4'd0, 1'b0);
    feed(0, 1'b1, 1'b0, -1);
    feed(1, 1'b1, 1'b0, -1);
    feed(2, 1'b1, 1'b1, -1);
    chk("gate_busy", 64'(busy), 64'(1));
    chk("gate_src", 64'(trig_src), 64'(0));
    feed(3, 1'b1, 1'b0, -1);
    feed(4, 1'b1, 1'b0, -1);
    chk("gate_wait", 64'(done), 64'(0));
    feed(5, 1'b1, 1'b1, -1);
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_count", 64'(count), 64'(6));
    chk("zero_idx", 64'(trig_idx), 64'(5));
    chk("gate_src_ext", 64'(trig_src), 64'(5'b10000));

    // post_cnt=15 clamps to 11 post samples.
    arm(4'd15, 1'b0);
    for (int n = 0; n < 15; n++) feed(n, 1'b1, n == 4, -1);
    chk("clamp_notdone", 64'(done), 64'(0));
    feed(15, 1'b1, 1'b0, -1);
    chk("clamp_done", 64'(done), 64'(1));
    chk("clamp_count", 64'(count), 64'(16));
    chk("clamp_idx", 64'(trig_idx), 64'(4));
    rd(0, hist[0], "clamp_rd0");
    rd(15, hist[15], "clamp_rd15");

    // Abort from POST.
    arm(4'd5, 1'b0);
    for (int n = 0; n < 7; n++) feed(n, 1'b1, n == 4, -1);
    chk("abort_pre", 64'(busy), 64'(1));
    collect = 1'b0;
    tick();
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));

    // Async reset in WAIT_TRIG, then a normal capture.
    collect = 1'b1;
    tick();
    chk("rearm_busy", 64'(busy), 64'(1));
    for (int n = 0; n < 6; n++) feed(n, 1'b1, 1'b0, -1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_rd", rd_data, 64'(0));
    chk("arst_count", 64'(count), 64'(0));
    collect = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    arm(4'd2, 1'b0);
    for (int n = 0; n < 9; n++) feed(n, 1'b1, n == 6, -1);
    chk("post_rst_done", 64'(done), 64'(1));
    chk("post_rst_count", 64'(count), 64'(9));
    chk("post_rst_idx", 64'(trig_idx), 64'(6));
    rd(8, hist[8], "post_rst_rd8");

    // Valid gaps; trig_ext on invalid cycles must be ignored.
    arm(4'd1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      feed(k, 1'b1, k == 4, -1);
      feed(100 + k, 1'b0, k >= 3, -1);
    end
    chk("gap_notdone", 64'(done), 64'(0));
    feed(5, 1'b1, 1'b0, -1);
    chk("gap_done", 64'(done), 64'(1));
    chk("gap_count", 64'(count), 64'(6));
    chk("gap_idx", 64'(trig_idx), 64'(4));
    rd(2, hist[2], "gap_rd2");
    rd_addr = 4'd3;
    #2;
    chk("lat_hold", rd_data, hist[2]);
    tick();
    chk("lat_new", rd_data, hist[3]);
    rd(5, hist[5], "gap_rd5");
    rd(5, hist[5], "gap_rd5b");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
